fifo_axis_reader: RTL and testbench

//  Read-side engine for the shared fifo: pops first-word-fall-through entries and

---
 rtl/fifo_axis_reader.sv | 135 +++++++++++++
 tb/tb_fifo_axis_reader.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_reader.sv
// Pops FWFT fifo entries and emits them as AXI-Stream packets of cfg_len beats with TLAST.
// Optional stall counter enabled by defining FIFO_RD_STALL_CNT_EN.
module fifo_axis_reader #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LEN_W   = 10
`ifdef FIFO_RD_STALL_CNT_EN
    ,
    parameter int unsigned STALL_W = 16
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   cfg_len,
    output logic               busy,
    output logic               done,
    input  logic               fifo_empty,
    input  logic [WIDTH-1:0]   fifo_data,
    output logic               fifo_r_ready,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [WIDTH-1:0]   m_tdata,
    output logic               m_tlast
`ifdef FIFO_RD_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   issued_q, issued_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               last_q, last_d;
    logic               can_load;
    logic               pop;
    logic               start_ok;

    assign start_ok = (state_q == StIdle) && start && (cfg_len != '0);
    assign can_load = !valid_q || m_tready;
    // Gated by reset so the cycle that aborts a packet never consumes a fifo entry.
    assign pop      = (state_q == StRun) && !fifo_empty && can_load
                      && (issued_q < len_q) && !reset;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        issued_d = issued_q;
        valid_d  = valid_q;
        data_d   = data_q;
        last_d   = last_q;

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    len_d    = cfg_len;
                    issued_d = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (valid_q && m_tready && last_q) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (pop) begin
            data_d   = fifo_data;
            valid_d  = 1'b1;
            issued_d = issued_q + LEN_W'(1);
            last_d   = (issued_q == len_q - LEN_W'(1));
        end else if (m_tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            len_q    <= '0;
            issued_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            last_q   <= last_d;
        end
    end

`ifdef FIFO_RD_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = '0;
        end else if (valid_q && !m_tready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign busy         = (state_q == StRun);
    assign done         = (state_q == StDone);
    assign fifo_r_ready = pop;
    assign m_tvalid     = valid_q;
    assign m_tdata      = data_q;
    assign m_tlast      = last_q;

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Scoreboard bench for fifo_axis_reader: a queue models the fifo, expected beats are
// queued at packet start and compared at each stream handshake.
module tb_fifo_axis_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  cfg_len = '0;
    logic        busy, done;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = '0;
    logic        fifo_r_ready;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [31:0] m_tdata;
    logic        m_tlast;
`ifdef FIFO_RD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic [31:0] fq[$];
    logic [31:0] exp_data[$];
    logic        exp_last[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          pops = 0;

    always #5 clk = ~clk;

    fifo_axis_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_len      (cfg_len),
        .busy         (busy),
        .done         (done),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_r_ready (fifo_r_ready),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast)
`ifdef FIFO_RD_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    task automatic refresh();
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? 32'd0 : fq[0];
    endtask

    // One clock: the fifo model pops when the strobe was high before the edge.
    task automatic tick();
        logic pop;
        #1;
        pop = fifo_r_ready;
        @(posedge clk);
        #1;
        if (pop && fq.size() != 0) begin
            fq.delete(0);
            pops++;
        end
        refresh();
        @(negedge clk);
    endtask

    task automatic fill(input int base, input int n);
        for (int i = 0; i < n; i++) fq.push_back(32'(base + i));
        refresh();
    endtask

    task automatic expect_packet(input int len);
        for (int i = 0; i < len; i++) begin
            exp_data.push_back(fq[i]);
            exp_last.push_back(i == len - 1);
        end
    endtask

    task automatic do_start(input int len);
        start   = 1'b1;
        cfg_len = 10'(len);
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || fifo_r_ready !== 1'b0 || m_tvalid !== 1'b0
            || m_tdata !== 32'd0 || m_tlast !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b rr=%b tvalid=%b tdata=%0h tlast=%b, all 0 required",
                     busy, done, fifo_r_ready, m_tvalid, m_tdata, m_tlast);
        end
`ifdef FIFO_RD_STALL_CNT_EN
        vectors++;
        if (stall_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_stall_cnt: got %0d required 0", stall_cnt);
        end
`endif
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int dones = 0;
        int done_cyc = -1;
        int bc[$];
        logic [31:0] ed;
        logic el;
        fill(0, 4);
        expect_packet(4);
        m_tready = 1'b1;
        pops = 0;
        do_start(4);
        for (int c = 0; c < 20; c++) begin
            if (m_tvalid && m_tready) begin
                vectors++;
                ed = exp_data.pop_front();
                el = exp_last.pop_front();
                bc.push_back(c);
                if (m_tdata !== ed || m_tlast !== el) begin
                    miscompares++;
                    $display("FAIL basic_beat: got %0d/%b required %0d/%b", m_tdata, m_tlast, ed, el);
                end
            end
            if (done) begin
                dones++;
                done_cyc = c;
            end
            tick();
        end
        vectors++;
        if (bc.size() != 4 || bc[3] - bc[0] != 3) begin
            miscompares++;
            $display("FAIL basic_consecutive: got %0d beats, 4 beats on consecutive cycles required", bc.size());
        end
        vectors++;
        if (dones != 1 || bc.size() != 4 || done_cyc != bc[3] + 1) begin
            miscompares++;
            $display("FAIL basic_done: got %0d pulses at cycle %0d, one pulse right after last beat required",
                     dones, done_cyc);
        end
        vectors++;
        if (pops != 4) begin
            miscompares++;
            $display("FAIL basic_pops: got %0d required 4", pops);
        end
    endtask

    task automatic test_partial();
        int dones;
        logic [31:0] ed;
        logic el;
        fill(100, 10);
        for (int p = 0; p < 2; p++) begin
            int len = (p == 0) ? 3 : 7;
            dones = 0;
            pops = 0;
            expect_packet(len);
            do_start(len);
            for (int c = 0; c < 20; c++) begin
                if (m_tvalid && m_tready) begin
                    vectors++;
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    if (m_tdata !== ed || m_tlast !== el) begin
                        miscompares++;
                        $display("FAIL partial_beat: got %0d/%b required %0d/%b", m_tdata, m_tlast, ed, el);
                    end
                end
                if (done) dones++;
                tick();
            end
            vectors++;
            if (pops != len || fq.size() != 10 - ((p == 0) ? 3 : 10) || dones != 1) begin
                miscompares++;
                $display("FAIL partial_pkt%0d: pops=%0d left=%0d dones=%0d, required pops=%0d left=%0d dones=1",
                         p, pops, fq.size(), dones, len, (p == 0) ? 7 : 0);
            end
        end
    endtask

    task automatic test_stall();
        int beats = 0;
        int stall_left = 4;
        logic [31:0] held_d = '0;
        logic held_l = 1'b0;
        logic [31:0] ed;
        logic el;
        fill(500, 5);
        expect_packet(5);
        do_start(5);
        for (int c = 0; c < 25; c++) begin
            m_tready = 1'b1;
            if (m_tvalid && beats == 1 && stall_left > 0) begin
                if (stall_left == 4) begin
                    held_d = m_tdata;
                    held_l = m_tlast;
                end
                m_tready = 1'b0;
                stall_left--;
            end
            #1;
            if (!m_tready) begin
                vectors++;
                if (m_tdata !== held_d || m_tlast !== held_l || fifo_r_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_hold: got %0d/%b rr=%b required %0d/%b rr=0",
                             m_tdata, m_tlast, fifo_r_ready, held_d, held_l);
                end
            end
            if (m_tvalid && m_tready) begin
                vectors++;
                beats++;
                ed = exp_data.pop_front();
                el = exp_last.pop_front();
                if (m_tdata !== ed || m_tlast !== el) begin
                    miscompares++;
                    $display("FAIL stall_beat: got %0d/%b required %0d/%b", m_tdata, m_tlast, ed, el);
                end
            end
            tick();
        end
        m_tready = 1'b1;
        vectors++;
        if (beats != 5 || stall_left != 0) begin
            miscompares++;
            $display("FAIL stall_count_beats: got %0d beats %0d stalls left, required 5 and 0",
                     beats, stall_left);
        end
`ifdef FIFO_RD_STALL_CNT_EN
        vectors++;
        if (stall_cnt !== 16'd4) begin
            miscompares++;
            $display("FAIL stall_cnt: got %0d required 4", stall_cnt);
        end
`endif
    endtask

    task automatic test_underflow();
        int beats = 0;
        int gap = 0;
        int dones = 0;
        logic [31:0] ed;
        logic el;
        fill(200, 2);
        for (int i = 0; i < 4; i++) begin
            exp_data.push_back(32'(200 + i));
            exp_last.push_back(i == 3);
        end
        pops = 0;
        do_start(4);
        for (int c = 0; c < 30; c++) begin
            if (c == 12) fill(202, 2);
            if (busy && beats == 2 && !m_tvalid) gap++;
            if (m_tvalid && m_tready) begin
                vectors++;
                beats++;
                ed = exp_data.pop_front();
                el = exp_last.pop_front();
                if (m_tdata !== ed || m_tlast !== el) begin
                    miscompares++;
                    $display("FAIL underflow_beat: got %0d/%b required %0d/%b", m_tdata, m_tlast, ed, el);
                end
            end
            if (done) dones++;
            tick();
        end
        vectors++;
        if (gap == 0 || beats != 4 || dones != 1 || pops != 4) begin
            miscompares++;
            $display("FAIL underflow_pkt: gap=%0d beats=%0d dones=%0d pops=%0d, required gap>0 4 1 4",
                     gap, beats, dones, pops);
        end
    endtask

    task automatic test_ignored_start();
        int beats = 0;
        int dones = 0;
        logic [31:0] ed;
        logic el;
        fill(300, 3);
        pops = 0;
        do_start(0);
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (busy !== 1'b0 || fifo_r_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_len: busy=%b rr=%b required 0 0", busy, fifo_r_ready);
            end
            tick();
        end
        expect_packet(3);
        do_start(3);
        for (int c = 0; c < 20; c++) begin
            if (c == 2) begin
                start   = 1'b1;
                cfg_len = 10'd1;
            end
            if (m_tvalid && m_tready) begin
                vectors++;
                beats++;
                ed = exp_data.pop_front();
                el = exp_last.pop_front();
                if (m_tdata !== ed || m_tlast !== el) begin
                    miscompares++;
                    $display("FAIL restart_beat: got %0d/%b required %0d/%b", m_tdata, m_tlast, ed, el);
                end
            end
            if (done) dones++;
            tick();
            start = 1'b0;
        end
        vectors++;
        if (beats != 3 || pops != 3 || dones != 1 || fq.size() != 0) begin
            miscompares++;
            $display("FAIL restart_pkt: beats=%0d pops=%0d dones=%0d left=%0d, required 3 3 1 0",
                     beats, pops, dones, fq.size());
        end
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        bit did_reset = 0;
        logic [31:0] ed;
        logic el;
        fill(400, 6);
        expect_packet(6);
        do_start(6);
        for (int c = 0; c < 10 && !did_reset; c++) begin
            if (m_tvalid && beats == 1) begin
                reset = 1'b1;
                tick();
                did_reset = 1;
                vectors++;
                if (busy !== 1'b0 || done !== 1'b0 || fifo_r_ready !== 1'b0 || m_tvalid !== 1'b0
                    || m_tdata !== 32'd0 || m_tlast !== 1'b0 || fq.size() != 4) begin
                    miscompares++;
                    $display("FAIL reset_mid: busy=%b tvalid=%b tdata=%0d tlast=%b left=%0d, required 0s and left=4",
                             busy, m_tvalid, m_tdata, m_tlast, fq.size());
                end
                reset = 1'b0;
            end else begin
                if (m_tvalid && m_tready) begin
                    vectors++;
                    beats++;
                    ed = exp_data.pop_front();
                    el = exp_last.pop_front();
                    if (m_tdata !== ed || m_tlast !== el) begin
                        miscompares++;
                        $display("FAIL reset_mid_beat: got %0d/%b required %0d/%b", m_tdata, m_tlast, ed, el);
                    end
                end
                tick();
            end
        end
        vectors++;
        if (!did_reset) begin
            miscompares++;
            $display("FAIL reset_mid_timeout: beat 2 never presented, required within 10 cycles");
        end
        exp_data.delete();
        exp_last.delete();
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0 || fq.size() != 4) begin
            miscompares++;
            $display("FAIL reset_mid_idle: busy=%b tvalid=%b left=%0d, required 0 0 4",
                     busy, m_tvalid, fq.size());
        end
        fq.delete();
        refresh();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_partial();
        test_stall();
        test_underflow();
        test_ignored_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
